// File: rtl/vslc_pkg.sv
// Shared types and default parameters for the VSLC scan-cycle sequencer.
// Used by the sequencer top, its period timer and its bus interface.
package vslc_pkg;

  localparam int unsigned PC_W_DEF       = 5;
  localparam int unsigned PER_W_DEF      = 16;
  localparam int unsigned WDT_CYCLES_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    LATCH,
    FETCH,
    EXEC,
    COMMIT
  } scan_state_t;

  // A scan is in progress from the input snapshot through the output commit.
  function automatic logic is_busy(input scan_state_t s);
    return (s == LATCH) || (s == FETCH) || (s == EXEC) || (s == COMMIT);
  endfunction

endpackage

// File: rtl/vslc_scan_sequencer_if.sv
// Fetch handshake and datapath strobes between the sequencer (master)
// and the program memory / ALU-IO datapath (slave).
interface vslc_scan_sequencer_if #(
  parameter int unsigned PC_W = vslc_pkg::PC_W_DEF
);

  logic [PC_W-1:0] pc;
  logic            fetch_req;
  logic            fetch_ack;
  logic            halt_instr;
  logic            in_latch;
  logic            exec_en;
  logic            out_commit;

  modport master (
    output pc, fetch_req, in_latch, exec_en, out_commit,
    input  fetch_ack, halt_instr
  );

  modport slave (
    input  pc, fetch_req, in_latch, exec_en, out_commit,
    output fetch_ack, halt_instr
  );

endinterface

// File: rtl/vslc_period_timer.sv
// Scan period down-counter: loaded when scanning starts, reloaded on every
// tick, so ticks recur every max(scan_period,1) enabled cycles.
module vslc_period_timer
  import vslc_pkg::*;
#(
  parameter int unsigned PER_W = PER_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic             active,
  input  logic [PER_W-1:0] scan_period,
  output logic             tick
);

  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] reload;

  // A period of zero behaves exactly like a period of one.
  assign reload = (scan_period == '0) ? '0 : scan_period - 1'b1;
  assign tick   = active && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (ena) begin
      if (load) begin
        cnt_d = reload;
      end else if (active) begin
        cnt_d = (cnt_q == '0) ? reload : cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vslc_scan_sequencer.sv
// PLC-style scan-cycle controller: snapshot inputs, fetch/execute the program,
// commit outputs once per scan period, with overrun and fetch-watchdog faults.
module vslc_scan_sequencer
  import vslc_pkg::*;
#(
  parameter int unsigned PC_W       = PC_W_DEF,
  parameter int unsigned PER_W      = PER_W_DEF,
  parameter int unsigned WDT_CYCLES = WDT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  run,
  input  logic [PC_W-1:0]       prog_len,
  input  logic [PER_W-1:0]      scan_period,
  vslc_scan_sequencer_if.master bus,
  output logic                  busy,
  output logic                  overrun,
  output logic                  fault,
  output logic [7:0]            scan_count
);

  localparam int unsigned WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  scan_state_t      state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic [7:0]       scan_count_q, scan_count_d;
  logic             overrun_q, overrun_d;
  logic             fault_q, fault_d;
  logic             tick;

  vslc_period_timer #(
    .PER_W(PER_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .load       ((state_q == IDLE) && run),
    .active     (state_q != IDLE),
    .scan_period(scan_period),
    .tick       (tick)
  );

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the previous cycle's values regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      wdt_q        <= '0;
      scan_count_q <= '0;
      overrun_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      wdt_q        <= wdt_d;
      scan_count_q <= scan_count_d;
      overrun_q    <= overrun_d;
      fault_q      <= fault_d;
    end
  end

  // NOTE: every signal gets a hold default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    wdt_d        = wdt_q;
    scan_count_d = scan_count_q;
    overrun_d    = overrun_q;
    fault_d      = fault_q;
    if (ena) begin
      // Ticks during a scan are dropped, not queued.
      if (tick && is_busy(state_q)) overrun_d = 1'b1;
      unique case (state_q)
        IDLE: begin
          if (run) begin
            state_d   = WAIT_TICK;
            overrun_d = 1'b0;
            fault_d   = 1'b0;
          end
        end
        WAIT_TICK: begin
          if (!run)      state_d = IDLE;
          else if (tick) state_d = LATCH;
        end
        LATCH: begin
          pc_d    = '0;
          state_d = FETCH;
        end
        FETCH: begin
          if (bus.fetch_ack) begin
            state_d = EXEC;
          end else if (wdt_q == WDT_LAST) begin
            fault_d = 1'b1;
            pc_d    = '0;
            wdt_d   = '0;
            state_d = IDLE;
          end else begin
            wdt_d = wdt_q + 1'b1;
          end
        end
        EXEC: begin
          wdt_d = '0;
          if (bus.halt_instr || (pc_q == prog_len)) begin
            state_d = COMMIT;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = FETCH;
          end
        end
        COMMIT: begin
          scan_count_d = scan_count_q + 8'd1;
          state_d      = run ? WAIT_TICK : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_latch   = ena && (state_q == LATCH);
    bus.fetch_req  = ena && (state_q == FETCH);
    bus.exec_en    = ena && (state_q == EXEC);
    bus.out_commit = ena && (state_q == COMMIT);
    bus.pc         = pc_q;
    busy           = is_busy(state_q);
    overrun        = overrun_q;
    fault          = fault_q;
    scan_count     = scan_count_q;
  end

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// Self-checking bench for vslc_scan_sequencer: randomized scans scored against
// an event-time model, plus halt, overrun, watchdog, freeze and reset scenarios.
module tb_vslc_scan_sequencer;
  import vslc_pkg::*;

  localparam int PC_W  = 5;
  localparam int PER_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             run = 1'b0;
  logic [PC_W-1:0]  prog_len = '0;
  logic [PER_W-1:0] scan_period = '0;
  logic             busy, overrun, fault;
  logic [7:0]       scan_count;

  // Memory responder: per-fetch wait latency, optional ack withholding, END marker.
  logic            no_ack = 1'b0;
  logic [PC_W-1:0] halt_at = '1;
  int              lat_mem [256];
  logic [7:0]      fidx = '0;
  int              wcnt = 0;
  int              cyc = 0;

  int n_checks = 0;
  int n_pass = 0;
  int exp_count = 0;

  int latch_q[$];
  int exec_c_q[$];
  int exec_pc_q[$];
  int commit_q[$];

  vslc_scan_sequencer_if #(.PC_W(PC_W)) bus ();

  vslc_scan_sequencer #(
    .PC_W(PC_W), .PER_W(PER_W), .WDT_CYCLES(64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .run        (run),
    .prog_len   (prog_len),
    .scan_period(scan_period),
    .bus        (bus),
    .busy       (busy),
    .overrun    (overrun),
    .fault      (fault),
    .scan_count (scan_count)
  );

  always #5 clk = ~clk;

  assign bus.fetch_ack  = bus.fetch_req && !no_ack && (wcnt >= lat_mem[fidx]);
  assign bus.halt_instr = (bus.pc == halt_at);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.exec_en) fidx <= fidx + 8'd1;
    if (bus.fetch_req && !bus.fetch_ack) wcnt <= wcnt + 1;
    else                                 wcnt <= 0;
  end

  always @(negedge clk) begin
    if (bus.in_latch)   latch_q.push_back(cyc);
    if (bus.exec_en) begin
      exec_c_q.push_back(cyc);
      exec_pc_q.push_back(int'(bus.pc));
    end
    if (bus.out_commit) commit_q.push_back(cyc);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int q_at(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  // Scans are predicted from timing rules: ticks every P cycles, a fetch lasts
  // latency+1 cycles, each execute one cycle; a scan starts at the first tick
  // that lands after the previous commit. run is dropped during the last scan.
  task automatic run_scan_test(input string tag, input int per, input int plen,
                               input int halt, input int nscans, input bit rand_lat);
    int         peff, s, c, cm, n_inst, nxt, t_run, li, ei, ci;
    bit         ov;
    logic [7:0] p;
    int         exp_latch[$], exp_exec_c[$], exp_exec_pc[$], exp_commit[$];

    p = fidx;
    for (int i = 0; i < 64; i++) begin
      lat_mem[p] = rand_lat ? int'($urandom_range(0, 3)) : 0;
      p = p + 8'd1;
    end

    step();
    scan_period = PER_W'(per);
    prog_len    = PC_W'(plen);
    halt_at     = PC_W'(halt);
    run         = 1'b1;
    t_run       = cyc;
    li = latch_q.size();
    ei = exec_c_q.size();
    ci = commit_q.size();

    peff   = (per == 0) ? 1 : per;
    s      = t_run + peff + 1;
    ov     = 1'b0;
    p      = fidx;
    n_inst = ((halt < plen) ? halt : plen) + 1;
    for (int k = 0; k < nscans; k++) begin
      exp_latch.push_back(s);
      c = s + 1;
      for (int i = 0; i < n_inst; i++) begin
        c = c + lat_mem[p] + 1;
        p = p + 8'd1;
        exp_exec_c.push_back(c);
        exp_exec_pc.push_back(i);
        c = c + 1;
      end
      cm = c;
      exp_commit.push_back(cm);
      if (s + peff - 1 <= cm) ov = 1'b1;
      if (k < nscans - 1) begin
        nxt = s + peff;
        while (nxt < cm + 2) nxt = nxt + peff;
        s = nxt;
      end
    end

    while (cyc < s) step();
    check({tag, "_latch_at_drop"}, int'(bus.in_latch), 1);
    run = 1'b0;
    while (cyc < cm + 2 * peff + 6) step();

    check({tag, "_latch_n"}, latch_q.size() - li, nscans);
    foreach (exp_latch[k]) check({tag, "_latch_cyc"}, q_at(latch_q, li + k), exp_latch[k]);
    check({tag, "_exec_n"}, exec_c_q.size() - ei, exp_exec_c.size());
    foreach (exp_exec_c[k]) begin
      check({tag, "_exec_cyc"}, q_at(exec_c_q, ei + k), exp_exec_c[k]);
      check({tag, "_exec_pc"}, q_at(exec_pc_q, ei + k), exp_exec_pc[k]);
    end
    check({tag, "_commit_n"}, commit_q.size() - ci, nscans);
    foreach (exp_commit[k]) check({tag, "_commit_cyc"}, q_at(commit_q, ci + k), exp_commit[k]);
    exp_count = (exp_count + nscans) % 256;
    check({tag, "_overrun"}, int'(overrun), int'(ov));
    check({tag, "_busy_end"}, int'(busy), 0);
    check({tag, "_scan_count"}, int'(scan_count), exp_count);
  endtask

  task automatic watchdog_test();
    int n, ci;
    halt_at = '1;
    step();
    scan_period = 16'd3;
    prog_len    = 5'd3;
    no_ack      = 1'b1;
    run         = 1'b1;
    ci = commit_q.size();
    n  = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (bus.fetch_req) n++;
      else if (n > 0) break;
    end
    check("wdt_fetch_cycles", n, 64);
    check("wdt_fault_set", int'(fault), 1);
    check("wdt_req_dropped", int'(bus.fetch_req), 0);
    check("wdt_busy_idle", int'(busy), 0);
    check("wdt_pc_zero", int'(bus.pc), 0);
    run = 1'b0;
    repeat (3) step();
    check("wdt_fault_sticky", int'(fault), 1);
    check("wdt_no_commit", commit_q.size() - ci, 0);
    run = 1'b1;
    step();
    check("wdt_fault_cleared", int'(fault), 0);
    run    = 1'b0;
    no_ack = 1'b0;
    repeat (4) step();
  endtask

  task automatic freeze_test();
    int s, n, li, ei, ci;
    int exp_c[4];
    logic [7:0] p;
    p = fidx;
    for (int i = 0; i < 16; i++) begin
      lat_mem[p] = 0;
      p = p + 8'd1;
    end
    step();
    scan_period = 16'd12;
    prog_len    = 5'd3;
    halt_at     = '1;
    run         = 1'b1;
    li = latch_q.size();
    ei = exec_c_q.size();
    ci = commit_q.size();
    n  = 0;
    while (!bus.in_latch && n < 100) begin
      step();
      n++;
    end
    check("frz_latch_seen", int'(bus.in_latch), 1);
    s = cyc;
    while (cyc < s + 3) step();
    check("frz_fetch_pc1", int'(bus.pc), 1);
    ena = 1'b0;
    #1;
    check("frz_req_forced_off", int'(bus.fetch_req), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("frz_req_held_off", int'(bus.fetch_req), 0);
      check("frz_pc_held", int'(bus.pc), 1);
    end
    ena = 1'b1;
    n = 0;
    while (!(bus.exec_en && bus.pc == 5'd2) && n < 50) begin
      step();
      n++;
    end
    check("frz_exec_pc2_cyc", cyc, s + 16);
    run = 1'b0;
    while (cyc < s + 40) step();
    exp_c = '{s + 2, s + 14, s + 16, s + 18};
    check("frz_latch_n", latch_q.size() - li, 1);
    check("frz_exec_n", exec_c_q.size() - ei, 4);
    foreach (exp_c[k]) begin
      check("frz_exec_cyc", q_at(exec_c_q, ei + k), exp_c[k]);
      check("frz_exec_pc", q_at(exec_pc_q, ei + k), k);
    end
    check("frz_commit_n", commit_q.size() - ci, 1);
    check("frz_commit_cyc", q_at(commit_q, ci), s + 19);
    check("frz_busy_end", int'(busy), 0);
    exp_count = (exp_count + 1) % 256;
    check("frz_scan_count", int'(scan_count), exp_count);
  endtask

  task automatic reset_test();
    int n, ci;
    step();
    scan_period = 16'd8;
    prog_len    = 5'd5;
    halt_at     = '1;
    run         = 1'b1;
    ci = commit_q.size();
    n  = 0;
    while (!bus.fetch_req && n < 100) begin
      step();
      n++;
    end
    check("rst_fetch_seen", int'(bus.fetch_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_strobes_zero",
          int'({bus.in_latch, bus.exec_en, bus.out_commit, bus.fetch_req, busy, overrun, fault}), 0);
    check("rst_pc_zero", int'(bus.pc), 0);
    check("rst_count_zero", int'(scan_count), 0);
    exp_count = 0;
    step();
    run   = 1'b0;
    rst_n = 1'b1;
    repeat (30) step();
    check("rst_no_commit", commit_q.size() - ci, 0);
    check("rst_count_after", int'(scan_count), exp_count);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int h;
    repeat (3) step();
    check("reset_strobes",
          int'({bus.in_latch, bus.exec_en, bus.out_commit, bus.fetch_req, busy, overrun, fault}), 0);
    check("reset_pc", int'(bus.pc), 0);
    check("reset_scan_count", int'(scan_count), 0);
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (2) step();

    run_scan_test("basic", 20, 3, 31, 3, 1'b0);
    run_scan_test("halt", 30, 7, 1, 2, 1'b0);
    run_scan_test("ovr", 5, 7, 31, 3, 1'b0);
    run_scan_test("per0", 0, 0, 31, 3, 1'b1);
    for (int i = 0; i < 6; i++) begin
      h = int'($urandom_range(0, 9));
      if (h >= 8) h = 31;
      run_scan_test("rnd", int'($urandom_range(0, 40)), int'($urandom_range(0, 7)), h,
                    int'($urandom_range(2, 4)), 1'b1);
    end
    watchdog_test();
    freeze_test();
    reset_test();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
